// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: default geometry and FSM state encoding.
package serial_frame_rx_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam bit PARITY_EN_DEF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } state_t;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial line in, received word and status out. The receiver uses master, a consumer uses slave.
interface serial_frame_rx_if
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              din;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    input  din,
    output data, valid, parity_err, frame_err, busy
  );

  modport slave (
    output din,
    input  data, valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/serial_frame_rx_sipo_shift_reg.sv
// Serial-in parallel-out register; new bits enter at the MSB so an LSB-first stream lands in order.
module sipo_shift_reg
  import serial_frame_rx_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      if (W > 1) q <= {din, q[W-1:1]};
      else       q <= din;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Start/data/parity/stop frame receiver with break detection; one bit sampled per clock.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit PARITY_EN = PARITY_EN_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  serial_frame_rx_if.master bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sr_q;
  logic              perr_q;

  logic sr_clr, sr_shift;
  logic cnt_clr, cnt_inc, cnt_last;
  logic perr_load, out_load, ferr_set;

  assign cnt_last = (cnt_q == CNT_W'(DATA_W - 1));

  sipo_shift_reg #(.W(DATA_W)) u_sipo (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (sr_clr),
    .shift_en (sr_shift),
    .din      (bus.din),
    .q        (sr_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    sr_clr    = 1'b0;
    sr_shift  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    perr_load = 1'b0;
    out_load  = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.din) begin
          state_d = ST_DATA;
          sr_clr  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      ST_DATA: begin
        sr_shift = 1'b1;
        cnt_inc  = 1'b1;
        if (cnt_last) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        perr_load = 1'b1;
        state_d   = ST_STOP;
      end
      ST_STOP: begin
        if (bus.din) begin
          out_load = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = ST_BREAK;
        end
      end
      // A held-low line after a bad stop is a break, never a new start bit.
      ST_BREAK: begin
        if (bus.din) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Even parity over data plus parity bit: any odd count of ones is an error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          perr_q <= 1'b0;
    else if (perr_load) perr_q <= bus.din ^ (^sr_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.data       <= '0;
      bus.parity_err <= 1'b0;
      bus.valid      <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.valid     <= out_load;
      bus.frame_err <= ferr_set;
      bus.busy      <= (state_d != ST_IDLE);
      if (out_load) begin
        bus.data       <= sr_q;
        bus.parity_err <= PARITY_EN ? perr_q : 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8: number of data bits per frame.
REQ-002 Parameter PARITY_EN, default 1: 1 means a parity bit follows the data bits; 0 means no parity bit.
REQ-003 Port clk, input, 1: the single clock; all state updates occur on the rising edge.
REQ-004 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-005 Port din, input, 1: serial line (registered D flip-flop q output); idle level 1; one bit sampled per clock.
REQ-006 Port data, output, DATA_W: last received data word, LSB received first.
REQ-007 Port valid, output, 1: one-cycle pulse when data/parity_err are updated.
REQ-008 Port parity_err, output, 1: even-parity mismatch of the frame flagged by valid.
REQ-009 Port frame_err, output, 1: one-cycle pulse when the stop bit sampled 0.
REQ-010 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-011 FSM states SHALL be IDLE, DATA, PARITY, STOP, BREAK.
REQ-012 IDLE: din=0 -> DATA with bit counter cleared; din=1 -> stay in IDLE.
REQ-013 DATA: each cycle shifts din into the MSB of the shift register (LSB-first frame); the counter increments.
REQ-014 DATA exit: after DATA_W bits, go to PARITY if PARITY_EN=1, else go to STOP.
REQ-015 PARITY: latch perr = din XOR (XOR-reduce of the shift register), i.e. even parity over data plus parity bit; go to STOP.
REQ-016 STOP, din=1: at the same edge, data <= shift register, parity_err <= perr (0 if PARITY_EN=0), valid <= 1; go to IDLE.
REQ-017 STOP, din=0: frame_err <= 1, valid stays 0, data and parity_err are unchanged; go to BREAK.
REQ-018 BREAK: stay while din=0; din=1 -> IDLE. A 0 in BREAK is never treated as a start bit.
REQ-019 Latency: start bit sampled at edge N; data at N+1..N+DATA_W; parity at N+DATA_W+1; stop at the following edge; valid is high for the cycle after the stop edge.
REQ-020 Back-to-back frames: a start bit on the cycle immediately after the stop bit SHALL be accepted with no dead cycle.
REQ-021 valid and frame_err are registered, single-cycle, and never high together.
REQ-022 data and parity_err hold their values between valid pulses.
REQ-023 busy is a registered decode of state != IDLE.

Reset
REQ-024 rstn=0, asynchronously: state = IDLE; data = 0; valid = 0; parity_err = 0; frame_err = 0; busy = 0; shift register, counter and perr = 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no valid and no frame_err pulse; the first start bit after rstn rises is received normally.

Structure
REQ-026 Shared package: FSM state encoding constants, and the default DATA_W and PARITY_EN values.
REQ-027 One sub-module, sipo_shift_reg: a DATA_W-bit serial-in parallel-out register with shift enable and clear, reset by rstn; the FSM, counter and parity logic stay in serial_frame_rx.

Verification
REQ-028 Frame 0xA5: 0, then 1,0,1,0,0,1,0,1, parity 0, stop 1 -> valid for one cycle, data=0xA5, parity_err=0, frame_err=0.
REQ-029 Same frame with parity bit 1 -> valid pulse, data=0xA5, parity_err=1.
REQ-030 Frame 0x3C with stop bit 0, then din=0 for 5 more cycles, then 1 -> frame_err for one cycle, no valid, busy high until din returns to 1, data unchanged.
REQ-031 Back-to-back 0x3C then 0xFF (parity 0 each), no idle gap -> two valid pulses 11 cycles apart, data 0x3C then 0xFF.
REQ-032 Reset asserted after 4 data bits, then frame 0x81 -> all outputs 0 during reset; next valid gives data=0x81, parity_err=0.
REQ-033 din=1 for 20 cycles after reset -> busy, valid and frame_err stay 0.
